// File: rtl/hvac_sequencer.sv
// hvac_sequencer
// Compressor-protecting sequencer between climate decision logic and the
// heater/cooler drives. Enforces minimum on-time, minimum off-time, and an
// extra dead-time before switching between heating and cooling. At most one
// drive is ever active, and conflicting requests never start a drive.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-low reset
//   enable    - master permit; when low no new drive starts
//   heat_req  - heating request (level)
//   cool_req  - cooling request (level)
//   heater_en - heater drive (state == HEAT)
//   cooler_en - cooler drive (state == COOL)
//   busy      - min-on or min-off lockout in progress
//   conflict  - registered enable & heat_req & cool_req
//   state     - IDLE=0, HEAT=1, COOL=2, REST=3
module hvac_sequencer #(
  parameter int MIN_ON  = 8,
  parameter int MIN_OFF = 6,
  parameter int DEAD    = 4,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       heat_req,
  input  logic       cool_req,
  output logic       heater_en,
  output logic       cooler_en,
  output logic       busy,
  output logic       conflict,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2,
    REST = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ON_LIM   = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LIM  = CNT_W'(MIN_OFF - 1);
  localparam logic [CNT_W-1:0] XOFF_LIM = CNT_W'(MIN_OFF + DEAD - 1);

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic             last_heat;

  logic heat_ok;
  logic cool_ok;

  // A start is valid only with a single, permitted request.
  assign heat_ok = enable & heat_req & ~cool_req;
  assign cool_ok = enable & cool_req & ~heat_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      cnt       <= '0;
      last_heat <= 1'b1;
      conflict  <= 1'b0;
    end else begin
      conflict <= enable & heat_req & cool_req;
      // Counter defaults to saturating increment; any state change clears it.
      if (cnt != '1) cnt <= cnt + 1'b1;
      unique case (st)
        IDLE: begin
          if (heat_ok) begin
            st  <= HEAT;
            cnt <= '0;
          end else if (cool_ok) begin
            st  <= COOL;
            cnt <= '0;
          end
        end
        HEAT: begin
          // Min-on is never shortened, not even by enable dropping.
          if (!heat_ok && cnt >= ON_LIM) begin
            st        <= REST;
            cnt       <= '0;
            last_heat <= 1'b1;
          end
        end
        COOL: begin
          if (!cool_ok && cnt >= ON_LIM) begin
            st        <= REST;
            cnt       <= '0;
            last_heat <= 1'b0;
          end
        end
        REST: begin
          if (heat_ok && cnt >= (last_heat ? OFF_LIM : XOFF_LIM)) begin
            st  <= HEAT;
            cnt <= '0;
          end else if (cool_ok && cnt >= (last_heat ? XOFF_LIM : OFF_LIM)) begin
            st  <= COOL;
            cnt <= '0;
          end
        end
        default: begin
          st  <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end

  assign state     = st;
  assign heater_en = (st == HEAT);
  assign cooler_en = (st == COOL);

  always_comb begin
    busy = 1'b0;
    if ((st == HEAT || st == COOL) && cnt < ON_LIM) busy = 1'b1;
    if (st == REST && cnt < OFF_LIM) busy = 1'b1;
  end

endmodule

// File: tb/tb_hvac_sequencer.sv
module tb_hvac_sequencer;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       heat_req;
  logic       cool_req;
  logic       heater_en;
  logic       cooler_en;
  logic       busy;
  logic       conflict;
  logic [1:0] state;

  int pass_cnt;
  int total;

  hvac_sequencer #(.MIN_ON(8), .MIN_OFF(6), .DEAD(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .heat_req  (heat_req),
    .cool_req  (cool_req),
    .heater_en (heater_en),
    .cooler_en (cooler_en),
    .busy      (busy),
    .conflict  (conflict),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    total++;
    if (state !== 2'd0 || heater_en !== 1'b0 || cooler_en !== 1'b0 || busy !== 1'b0 || conflict !== 1'b0)
      $display("FAIL reset_init: state=%0d heater=%b cooler=%b busy=%b conflict=%b want 0/0/0/0/0",
               state, heater_en, cooler_en, busy, conflict);
    else pass_cnt++;
    rst = 1'b1;
    heat_req = 1'b1;
    step(1);
    total++;
    if (heater_en !== 1'b1) $display("FAIL reset_heat_start: heater=%b want 1", heater_en);
    else pass_cnt++;
    step(2);
    rst = 1'b0;
    #1;
    total++;
    if (heater_en !== 1'b0 || state !== 2'd0 || busy !== 1'b0)
      $display("FAIL reset_async: heater=%b state=%0d busy=%b want 0/0/0", heater_en, state, busy);
    else pass_cnt++;
    heat_req = 1'b0;
    #1 rst = 1'b1;
    step(5);
    total++;
    if (state !== 2'd0 || heater_en !== 1'b0 || cooler_en !== 1'b0)
      $display("FAIL reset_stay_idle: state=%0d heater=%b cooler=%b want 0/0/0", state, heater_en, cooler_en);
    else pass_cnt++;
  endtask

  task automatic test_pulse;
    heat_req = 1'b1;
    step(1);
    heat_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (heater_en !== 1'b1 || busy !== (i < 7))
        $display("FAIL pulse_cycle%0d: heater=%b busy=%b want 1/%b", i, heater_en, busy, (i < 7));
      else pass_cnt++;
      step(1);
    end
    total++;
    if (heater_en !== 1'b0 || state !== 2'd3 || busy !== 1'b1)
      $display("FAIL pulse_end: heater=%b state=%0d busy=%b want 0/3/1", heater_en, state, busy);
    else pass_cnt++;
  endtask

  task automatic test_restart;
    int lows;
    heat_req = 1'b1;
    lows = 0;
    while (heater_en === 1'b0 && lows < 50) begin
      lows++;
      step(1);
    end
    total++;
    if (lows != 6) $display("FAIL restart_same_gap: low_cycles=%0d want 6", lows);
    else pass_cnt++;
    heat_req = 1'b0;
    step(8);
    total++;
    if (heater_en !== 1'b0 || state !== 2'd3)
      $display("FAIL restart_min_on_end: heater=%b state=%0d want 0/3", heater_en, state);
    else pass_cnt++;
    step(50);
    total++;
    if (busy !== 1'b0) $display("FAIL restart_rest_idle_busy: busy=%b want 0", busy);
    else pass_cnt++;
    heat_req = 1'b1;
    step(1);
    total++;
    if (heater_en !== 1'b1) $display("FAIL restart_after_long_rest: heater=%b want 1", heater_en);
    else pass_cnt++;
  endtask

  task automatic test_handover;
    int lows;
    // HEAT is active with heat_req held; complete 12 cycles high.
    step(11);
    total++;
    if (heater_en !== 1'b1) $display("FAIL handover_held: heater=%b want 1", heater_en);
    else pass_cnt++;
    heat_req = 1'b0;
    cool_req = 1'b1;
    step(1);
    total++;
    if (heater_en !== 1'b0 || cooler_en !== 1'b0)
      $display("FAIL handover_drop: heater=%b cooler=%b want 0/0", heater_en, cooler_en);
    else pass_cnt++;
    lows = 0;
    while (heater_en === 1'b0 && cooler_en === 1'b0 && lows < 60) begin
      lows++;
      step(1);
    end
    total++;
    if (lows != 10) $display("FAIL handover_gap: low_cycles=%0d want 10", lows);
    else pass_cnt++;
    total++;
    if (cooler_en !== 1'b1 || heater_en !== 1'b0 || state !== 2'd2)
      $display("FAIL handover_cool: cooler=%b heater=%b state=%0d want 1/0/2", cooler_en, heater_en, state);
    else pass_cnt++;
    cool_req = 1'b0;
    step(8);
    total++;
    if (state !== 2'd3 || cooler_en !== 1'b0)
      $display("FAIL handover_cool_end: state=%0d cooler=%b want 3/0", state, cooler_en);
    else pass_cnt++;
  endtask

  task automatic test_conflict;
    #1 rst = 1'b0;
    #1 rst = 1'b1;
    heat_req = 1'b1;
    cool_req = 1'b1;
    enable   = 1'b1;
    step(1);
    total++;
    if (conflict !== 1'b1 || heater_en !== 1'b0 || cooler_en !== 1'b0 || state !== 2'd0)
      $display("FAIL conflict_flag: conflict=%b heater=%b cooler=%b state=%0d want 1/0/0/0",
               conflict, heater_en, cooler_en, state);
    else pass_cnt++;
    cool_req = 1'b0;
    enable   = 1'b0;
    step(1);
    total++;
    if (conflict !== 1'b0) $display("FAIL conflict_clear: conflict=%b want 0", conflict);
    else pass_cnt++;
    step(3);
    total++;
    if (heater_en !== 1'b0 || state !== 2'd0)
      $display("FAIL enable_block: heater=%b state=%0d want 0/0", heater_en, state);
    else pass_cnt++;
    enable = 1'b1;
    step(1);
    total++;
    if (heater_en !== 1'b1) $display("FAIL enable_start: heater=%b want 1", heater_en);
    else pass_cnt++;
    heat_req = 1'b0;
    step(8);
    total++;
    if (state !== 2'd3) $display("FAIL conflict_rest: state=%0d want 3", state);
    else pass_cnt++;
  endtask

  task automatic test_saturation;
    step(300);
    total++;
    if (dut.cnt !== 8'hff || state !== 2'd3)
      $display("FAIL sat_count: cnt=%0d state=%0d want 255/3", dut.cnt, state);
    else pass_cnt++;
    cool_req = 1'b1;
    step(1);
    total++;
    if (cooler_en !== 1'b1 || heater_en !== 1'b0)
      $display("FAIL sat_cool_start: cooler=%b heater=%b want 1/0", cooler_en, heater_en);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total    = 0;
    rst      = 1'b0;
    enable   = 1'b1;
    heat_req = 1'b0;
    cool_req = 1'b0;
    #3;
    test_reset;
    test_pulse;
    test_restart;
    test_handover;
    test_conflict;
    test_saturation;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
